ntt_stage_ctrl: RTL and testbench

NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

---
 rtl/ntt_stage_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_ctrl.sv
// NTT stage controller: CT / GS / PWM address sequencing for one butterfly.
// Optional stall input enabled with macro NTT_CTRL_STALL_EN.
module ntt_stage_ctrl #(
    parameter int LOGN    = 8,
    parameter int BUF_LAT = 5
) (
    input  logic            iSYS_CLK,
    input  logic            iSYS_RST,
    input  logic            iFSM_START,
    input  logic [1:0]      iFSM_MODE,
`ifdef NTT_CTRL_STALL_EN
    input  logic            iSTALL,
`endif
    output logic            oFSM_sel,
    output logic            oBUF_EN,
    output logic            oRD_EN,
    output logic [LOGN-1:0] oRD_ADDR_A,
    output logic [LOGN-1:0] oRD_ADDR_B,
    output logic [LOGN-1:0] oTW_ADDR,
    output logic            oWR_EN,
    output logic            oWR_DUAL,
    output logic [LOGN-1:0] oWR_ADDR_A,
    output logic [LOGN-1:0] oWR_ADDR_B,
    output logic            oBUSY,
    output logic            oDONE
);

    localparam int SW = $clog2(LOGN + 1);
    localparam int DW = $clog2(BUF_LAT + 1) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [LOGN-1:0] ONE      = {{(LOGN-1){1'b0}}, 1'b1};
    localparam logic [LOGN-1:0] ALL1     = {LOGN{1'b1}};
    localparam logic [LOGN-1:0] LAST_NTT = {1'b0, {(LOGN-1){1'b1}}};
    localparam logic [SW-1:0]   LASTSTG  = SW'(LOGN - 1);
    localparam logic [DW-1:0]   DRN_END  = DW'(BUF_LAT);

    logic [1:0]      state;
    logic [1:0]      modeReg;
    logic [LOGN-1:0] cnt;
    logic [SW-1:0]   stage;
    logic [DW-1:0]   dcnt;

    logic            isGs;
    logic            isPwm;
    logic            stall;
    logic            rdEn;
    logic            lastRd;
    logic [LOGN-1:0] lastCnt;
    logic [SW-1:0]   b;
    logic [LOGN-1:0] lenV;
    logic [LOGN-1:0] grp;
    logic [LOGN-1:0] rdA;
    logic [LOGN-1:0] rdB;
    logic [LOGN-1:0] tw;

    logic [BUF_LAT:0]           vld;
    logic [BUF_LAT:0][LOGN-1:0] dA;
    logic [BUF_LAT:0][LOGN-1:0] dB;

`ifdef NTT_CTRL_STALL_EN
    assign stall = iSTALL;
`else
    assign stall = 1'b0;
`endif

    assign isGs    = (modeReg == 2'd1);
    assign isPwm   = modeReg[1];
    assign rdEn    = (state == RUN) && !stall;
    assign lastCnt = isPwm ? ALL1 : LAST_NTT;
    assign lastRd  = rdEn && (cnt == lastCnt);

    // Pair addresses: insert a 0/1 bit at position log2(len) into the counter.
    always_comb begin
        b    = isGs ? stage : (LASTSTG - stage);
        lenV = ONE << b;
        grp  = cnt >> b;
        rdA  = '0;
        rdB  = '0;
        tw   = '0;
        if (rdEn) begin
            if (isPwm) begin
                rdA = cnt;
                rdB = cnt;
                tw  = cnt;
            end else begin
                rdA = ((grp << 1) << b) | (cnt & (lenV - ONE));
                rdB = rdA | lenV;
                tw  = isGs ? ((ALL1 >> stage) - grp)
                           : ((ONE << stage) + grp);
            end
        end
    end

    // Control FSM with per-stage read counter and drain timer.
    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            state   <= IDLE;
            modeReg <= '0;
            cnt     <= '0;
            stage   <= '0;
            dcnt    <= '0;
        end else begin
            unique case (state)
                IDLE: if (iFSM_START) begin
                    state   <= RUN;
                    modeReg <= iFSM_MODE;
                    cnt     <= '0;
                    stage   <= '0;
                end
                RUN: if (rdEn) begin
                    if (lastRd) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        dcnt  <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DRN_END) begin
                        if (isPwm || stage == LASTSTG) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            stage <= stage + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-to-write delay line: one RAM cycle plus butterfly latency.
    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            vld <= '0;
            dA  <= '0;
            dB  <= '0;
        end else begin
            vld[0] <= rdEn;
            dA[0]  <= rdA;
            dB[0]  <= rdB;
            for (int i = 1; i <= BUF_LAT; i++) begin
                vld[i] <= vld[i-1];
                dA[i]  <= dA[i-1];
                dB[i]  <= dB[i-1];
            end
        end
    end

    assign oRD_EN     = rdEn;
    assign oRD_ADDR_A = rdA;
    assign oRD_ADDR_B = rdB;
    assign oTW_ADDR   = tw;
    assign oWR_EN     = vld[BUF_LAT];
    assign oWR_DUAL   = vld[BUF_LAT] & ~isPwm;
    assign oWR_ADDR_A = dA[BUF_LAT];
    assign oWR_ADDR_B = dB[BUF_LAT];
    assign oBUSY      = (state != IDLE);
    assign oDONE      = (state == DONE);
    assign oBUF_EN    = (state == RUN) || (state == DRAIN);
    assign oFSM_sel   = isGs && (state != IDLE);

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: loop-nest schedule model plus per-cycle compare.
// Stall scenario is compiled in with NTT_CTRL_STALL_EN.
module tb_ntt_stage_ctrl;

    localparam int LOGN = 8;
    localparam int N    = 1 << LOGN;
    localparam int BL   = 5;
    localparam int MAXT = 1300;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      mode;
`ifdef NTT_CTRL_STALL_EN
    logic            stall = 1'b0;
`endif
    logic            sel, bufEn, rdEn, wrEn, wrDual, busy, done;
    logic [LOGN-1:0] rdA, rdB, twA, wrA, wrB;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int doneCnt = 0;
    int fRef = 0;
    int doneT = 0;
    int cutT = 0;
    bit cut = 0;
    bit active = 0;
    bit chkOn = 0;
    logic [1:0] curMode;

    bit expRd[MAXT];
    bit expWr[MAXT];
    int expA[MAXT], expB[MAXT], expTw[MAXT];
    int expWA[MAXT], expWB[MAXT];
    int rdTimes[$];

    ntt_stage_ctrl #(.LOGN(LOGN), .BUF_LAT(BL)) dut (
        .iSYS_CLK(clk),
        .iSYS_RST(rst),
        .iFSM_START(start),
        .iFSM_MODE(mode),
`ifdef NTT_CTRL_STALL_EN
        .iSTALL(stall),
`endif
        .oFSM_sel(sel),
        .oBUF_EN(bufEn),
        .oRD_EN(rdEn),
        .oRD_ADDR_A(rdA),
        .oRD_ADDR_B(rdB),
        .oTW_ADDR(twA),
        .oWR_EN(wrEn),
        .oWR_DUAL(wrDual),
        .oWR_ADDR_A(wrA),
        .oWR_ADDR_B(wrB),
        .oBUSY(busy),
        .oDONE(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    function automatic bit stalledAt(input int t, input int sFrom,
                                     input int sLen);
        return sLen > 0 && t >= sFrom && t < sFrom + sLen;
    endfunction

    task automatic putRd(inout int t, input int a, input int b2,
                         input int w, input int sFrom, input int sLen);
        while (stalledAt(t, sFrom, sLen)) t++;
        expRd[t] = 1'b1;
        expA[t]  = a;
        expB[t]  = b2;
        expTw[t] = w;
        expWr[t+BL+1] = 1'b1;
        expWA[t+BL+1] = a;
        expWB[t+BL+1] = b2;
        rdTimes.push_back(t);
        t++;
    endtask

    // Schedule from the loop nest: stages, groups, pairs, then drain.
    task automatic buildModel(input logic [1:0] m, input int sFrom,
                              input int sLen);
        int t, len, w;
        for (int i = 0; i < MAXT; i++) begin
            expRd[i] = 0; expWr[i] = 0;
            expA[i] = 0; expB[i] = 0; expTw[i] = 0;
            expWA[i] = 0; expWB[i] = 0;
        end
        rdTimes.delete();
        t = 0;
        curMode = m;
        if (m[1]) begin
            for (int i = 0; i < N; i++) putRd(t, i, i, i, sFrom, sLen);
            t += BL + 1;
        end else begin
            w = (m == 2'd1) ? N - 1 : 1;
            for (int s = 0; s < LOGN; s++) begin
                len = (m == 2'd1) ? (1 << s) : (N >> (s + 1));
                for (int g = 0; g < N / (2 * len); g++) begin
                    for (int j = 0; j < len; j++)
                        putRd(t, g * 2 * len + j, g * 2 * len + j + len,
                              w, sFrom, sLen);
                    w = (m == 2'd1) ? w - 1 : w + 1;
                end
                t += BL + 1;
            end
        end
        doneT = t;
    endtask

    // Per-cycle compare against the schedule, idle outputs otherwise.
    always @(negedge clk) begin
        int t;
        t = cyc - fRef;
        if (chkOn) begin
            if (active && t >= 0 && t <= doneT && !(cut && t > cutT)) begin
                chk("rd_en", 64'(rdEn), 64'(expRd[t]));
                if (expRd[t]) begin
                    chk("rd_a", 64'(rdA), 64'(expA[t]));
                    chk("rd_b", 64'(rdB), 64'(expB[t]));
                    chk("tw", 64'(twA), 64'(expTw[t]));
                end
                chk("wr_en", 64'(wrEn), 64'(expWr[t]));
                if (expWr[t]) begin
                    chk("wr_a", 64'(wrA), 64'(expWA[t]));
                    chk("wr_b", 64'(wrB), 64'(expWB[t]));
                    chk("wr_dual", 64'(wrDual), 64'(!curMode[1]));
                end
                chk("busy", 64'(busy), 64'd1);
                chk("done", 64'(done), 64'(t == doneT));
                chk("buf_en", 64'(bufEn), 64'(t < doneT));
                chk("sel", 64'(sel), 64'(curMode == 2'd1));
            end else begin
                chk("idle_outs",
                    64'({sel, bufEn, rdEn, rdA, rdB, twA, wrEn, wrDual,
                         wrA, wrB, busy, done}), 64'd0);
            end
        end
        if (done) doneCnt++;
    end

    task automatic runOp(input logic [1:0] m, input int sFrom,
                         input int sLen, input bit junk);
        int d0, t;
        @(posedge clk); #1;
        buildModel(m, sFrom, sLen);
        d0 = doneCnt;
        start = 1'b1;
        mode = m;
        fRef = cyc + 1;
        cut = 0;
        active = 1;
        for (int k = 0; k <= doneT + 4; k++) begin
            @(posedge clk); #1;
            t = cyc - fRef;
            start = junk && t > 0 && t < doneT - 5 && (t % 97 == 3);
            mode = junk ? ~m : m;
`ifdef NTT_CTRL_STALL_EN
            stall = stalledAt(t, sFrom, sLen);
`endif
        end
        start = 0;
        active = 0;
        chk("done_count", 64'(doneCnt - d0), 64'd1);
    endtask

    task automatic runResetMid();
        int d0;
        @(posedge clk); #1;
        buildModel(2'd0, 0, 0);
        d0 = doneCnt;
        start = 1'b1;
        mode = 2'd0;
        fRef = cyc + 1;
        cut = 0;
        active = 1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            start = 0;
        end
        @(posedge clk); #1;
        chk("rst_at_f300", 64'(cyc - fRef), 64'd300);
        cutT = 300;
        cut = 1;
        rst = 1;
        start = 1;
        @(posedge clk); #1;
        rst = 0;
        start = 0;
        repeat (20) @(posedge clk);
        #1;
        active = 0;
        chk("rst_no_done", 64'(doneCnt - d0), 64'd0);
    endtask

    initial begin
        rst = 1;
        start = 1;
        mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chkOn = 1;
        @(posedge clk); #1;
        rst = 0;
        start = 0;
        repeat (4) @(posedge clk);

        buildModel(2'd0, 0, 0);
        chk("m_ct_first_a", 64'(expA[rdTimes[0]]), 64'd0);
        chk("m_ct_first_b", 64'(expB[rdTimes[0]]), 64'd128);
        chk("m_ct_first_tw", 64'(expTw[rdTimes[0]]), 64'd1);
        chk("m_ct_s0_last_a", 64'(expA[rdTimes[127]]), 64'd127);
        chk("m_ct_s0_last_b", 64'(expB[rdTimes[127]]), 64'd255);
        chk("m_ct_last_tw", 64'(expTw[rdTimes[$]]), 64'd255);
        chk("m_ct_done", 64'(doneT), 64'd1072);
        runOp(2'd0, 0, 0, 0);

        buildModel(2'd1, 0, 0);
        chk("m_gs_first_b", 64'(expB[rdTimes[0]]), 64'd1);
        chk("m_gs_first_tw", 64'(expTw[rdTimes[0]]), 64'd255);
        chk("m_gs_ls_a", 64'(expA[rdTimes[896]]), 64'd0);
        chk("m_gs_ls_b", 64'(expB[rdTimes[896]]), 64'd128);
        chk("m_gs_last_tw", 64'(expTw[rdTimes[$]]), 64'd1);
        chk("m_gs_done", 64'(doneT), 64'd1072);
        runOp(2'd1, 0, 0, 1);

        buildModel(2'd2, 0, 0);
        chk("m_pwm_done", 64'(doneT), 64'd262);
        chk("m_pwm_wr6", 64'(expWr[6]), 64'd1);
        chk("m_pwm_wa6", 64'(expWA[6]), 64'd0);
        chk("m_pwm_wr5", 64'(expWr[5]), 64'd0);
        runOp(2'd2, 0, 0, 0);
        runOp(2'd3, 0, 0, 1);

        runResetMid();
        runOp(2'd0, 0, 0, 0);

`ifdef NTT_CTRL_STALL_EN
        buildModel(2'd0, 20, 10);
        chk("m_stall_done", 64'(doneT), 64'd1082);
        runOp(2'd0, 20, 10, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
